// File: rtl/pc_fetch_stage_pkg.sv
// rtl/pc_fetch_stage_pkg.sv - shared types, constants and helpers for the fetch stage
package pc_fetch_stage_pkg;

    localparam int          INSTR_W  = 32;
    localparam int          NEXTPC_W = 34;
    localparam logic [31:0] PC_STEP  = 32'd4;

    localparam logic [1:0] ST_BOOT  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;

    typedef struct packed {
        logic [31:0]        pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

    function automatic logic [31:0] align_target(input logic [NEXTPC_W-1:0] npc);
        return {npc[31:2], 2'b00};
    endfunction

    function automatic logic target_bad(input logic [NEXTPC_W-1:0] npc);
        return (npc[NEXTPC_W-1:32] != 2'b00) || (npc[1:0] != 2'b00);
    endfunction

endpackage

// File: rtl/pc_fetch_stage_if.sv
// rtl/pc_fetch_stage_if.sv - instruction memory and decode handshake bundle
interface pc_fetch_stage_if;
    import pc_fetch_stage_pkg::*;

    logic               imem_req;
    logic [31:0]        imem_addr;
    logic [INSTR_W-1:0] imem_rdata;
    logic               if_valid;
    logic               if_ready;
    logic [INSTR_W-1:0] if_instr;
    logic [31:0]        if_pc;

    modport master (
        output imem_req, imem_addr, if_valid, if_instr, if_pc,
        input  imem_rdata, if_ready
    );

    modport slave (
        input  imem_req, imem_addr, if_valid, if_instr, if_pc,
        output imem_rdata, if_ready
    );

endinterface

// File: rtl/pc_fetch_stage_fetch_fifo.sv
// rtl/pc_fetch_stage_fetch_fifo.sv - small {pc, instr} buffer with push/pop/clear
module fetch_fifo
    import pc_fetch_stage_pkg::*;
#(
    parameter int  DEPTH = 2,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear_i,
    input  logic             push_i,
    input  fetch_entry_t     push_data_i,
    input  logic             pop_i,
    output fetch_entry_t     head_o,
    output logic [CNT_W-1:0] count_o
);

    fetch_entry_t     mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [CNT_W-1:0] count_q;

    // Storage is not reset; the consumer masks the head while count is zero.
    always_ff @(posedge clk) begin
        if (!rst_n || clear_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_i) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_q + CNT_W'(push_i) - CNT_W'(pop_i);
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/pc_fetch_stage.sv
// rtl/pc_fetch_stage.sv - PC register, fetch issue, redirect flush and decode buffer
module pc_fetch_stage
    import pc_fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NEXTPC_W-1:0] next_pc_in,
    input  logic                redirect,
    pc_fetch_stage_if.master    fif,
    output logic                addr_err
);

    localparam int             CNT_W   = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(FIFO_DEPTH);

    logic [1:0]       state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic [31:0]      reqpc_q, reqpc_d;
    logic             inflight_q, inflight_d;
    logic             drop_q, drop_d;
    logic             addr_err_q, addr_err_d;

    logic [CNT_W-1:0] fifo_count;
    fetch_entry_t     fifo_head;
    fetch_entry_t     push_entry;
    logic             head_valid;
    logic             pop;
    logic             push;
    logic             req;
    logic [CNT_W:0]   occupancy;

    assign head_valid = (fifo_count != '0);
    assign pop        = head_valid & fif.if_ready;
    // Entries buffered plus the one on its way back, minus what decode takes now.
    assign occupancy  = {1'b0, fifo_count} + (CNT_W + 1)'(inflight_q) - (CNT_W + 1)'(pop);
    assign req        = (state_q != ST_BOOT) && (occupancy < DEPTH_C);
    assign push       = inflight_q & ~drop_q & ~redirect;
    assign push_entry = '{pc: reqpc_q, instr: fif.imem_rdata};

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear_i     (redirect),
        .push_i      (push),
        .push_data_i (push_entry),
        .pop_i       (pop & ~redirect),
        .head_o      (fifo_head),
        .count_o     (fifo_count)
    );

    always_comb begin
        state_d    = ST_RUN;
        pc_d       = pc_q;
        reqpc_d    = reqpc_q;
        inflight_d = req;
        drop_d     = drop_q;
        addr_err_d = addr_err_q;
        if (req) begin
            pc_d    = pc_q + PC_STEP;
            reqpc_d = pc_q;
        end
        if (inflight_q && drop_q) begin
            drop_d = 1'b0;
        end
        // A request leaving in the redirect cycle targets the old stream.
        if (redirect) begin
            state_d    = ST_FLUSH;
            pc_d       = align_target(next_pc_in);
            drop_d     = req;
            addr_err_d = addr_err_q | target_bad(next_pc_in);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_BOOT;
            pc_q       <= RESET_PC;
            reqpc_q    <= '0;
            inflight_q <= 1'b0;
            drop_q     <= 1'b0;
            addr_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            reqpc_q    <= reqpc_d;
            inflight_q <= inflight_d;
            drop_q     <= drop_d;
            addr_err_q <= addr_err_d;
        end
    end

    assign fif.imem_req  = req;
    assign fif.imem_addr = pc_q;
    assign fif.if_valid  = head_valid;
    assign fif.if_instr  = head_valid ? fifo_head.instr : '0;
    assign fif.if_pc     = head_valid ? fifo_head.pc : '0;
    assign addr_err      = addr_err_q;

endmodule

// File: tb/tb_pc_fetch_stage.sv
// tb/tb_pc_fetch_stage.sv - directed table, wrap sequence and randomized stream checks
module tb_pc_fetch_stage;
    import pc_fetch_stage_pkg::*;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        redirect;
    logic [33:0] next_pc_in;
    logic        addr_err;
    logic        rst_n_w;
    logic        redirect_w;
    logic [33:0] next_pc_w;
    logic        addr_err_w;

    pc_fetch_stage_if fif();
    pc_fetch_stage_if wif();

    pc_fetch_stage #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) u_dut (
        .clk(clk), .rst_n(rst_n), .next_pc_in(next_pc_in), .redirect(redirect),
        .fif(fif), .addr_err(addr_err)
    );

    pc_fetch_stage #(.RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(2)) u_wrap (
        .clk(clk), .rst_n(rst_n_w), .next_pc_in(next_pc_w), .redirect(redirect_w),
        .fif(wif), .addr_err(addr_err_w)
    );

    typedef struct {
        logic        rst;
        logic        rdy;
        logic        redir;
        logic [33:0] npc;
        logic        req;
        logic [31:0] addr;
        logic        vld;
        logic [31:0] pc;
        logic        err;
    } vec_t;

    vec_t vecs[$];
    int   checks   = 0;
    int   failures = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A3C_96E1;
    endfunction

    function automatic vec_t mk(input logic rst, input logic rdy, input logic redir,
                                input logic [33:0] npc, input logic req, input logic [31:0] addr,
                                input logic vld, input logic [31:0] pc, input logic err);
        vec_t v;
        v.rst = rst; v.rdy = rdy; v.redir = redir; v.npc = npc;
        v.req = req; v.addr = addr; v.vld = vld; v.pc = pc; v.err = err;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Memory answers one cycle after a request; otherwise it drives noise.
    task automatic tick();
        logic        r, rw;
        logic [31:0] a, aw;
        r  = fif.imem_req;
        a  = fif.imem_addr;
        rw = wif.imem_req;
        aw = wif.imem_addr;
        @(posedge clk);
        #1;
        fif.imem_rdata = r  ? mem_word(a)  : $urandom();
        wif.imem_rdata = rw ? mem_word(aw) : $urandom();
    endtask

    logic [31:0] w_addr [6] = '{32'hFFFF_FFF8, 32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0, 32'h4, 32'h8};
    logic        w_req  [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    logic        w_vld  [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [31:0] w_pc   [6] = '{32'h0, 32'h0, 32'h0, 32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0};

    initial begin
        logic [31:0] exp_next;
        logic        exp_err;
        int          since;
        logic [33:0] t;

        rst_n = 1'b0; redirect = 1'b0; next_pc_in = '0; fif.if_ready = 1'b0;
        rst_n_w = 1'b0; redirect_w = 1'b0; next_pc_w = '0; wif.if_ready = 1'b1;
        fif.imem_rdata = '0; wif.imem_rdata = '0;

        //            rst  rdy  rdr  npc              req  addr           vld  pc             err
        vecs.push_back(mk(0, 1, 0, 34'h0,            0, 32'h0,   0, 32'h0,   0));
        vecs.push_back(mk(1, 1, 0, 34'h0,            0, 32'h0,   0, 32'h0,   0));
        vecs.push_back(mk(1, 1, 0, 34'h0,            1, 32'h0,   0, 32'h0,   0));
        vecs.push_back(mk(1, 1, 0, 34'h0,            1, 32'h4,   0, 32'h0,   0));
        vecs.push_back(mk(1, 1, 0, 34'h0,            1, 32'h8,   1, 32'h0,   0));
        vecs.push_back(mk(1, 1, 0, 34'h0,            1, 32'hC,   1, 32'h4,   0));
        vecs.push_back(mk(1, 0, 0, 34'h0,            0, 32'h10,  1, 32'h8,   0));
        vecs.push_back(mk(1, 0, 0, 34'h0,            0, 32'h10,  1, 32'h8,   0));
        vecs.push_back(mk(1, 0, 0, 34'h0,            0, 32'h10,  1, 32'h8,   0));
        vecs.push_back(mk(1, 1, 0, 34'h0,            1, 32'h10,  1, 32'h8,   0));
        vecs.push_back(mk(1, 1, 0, 34'h0,            1, 32'h14,  1, 32'hC,   0));
        vecs.push_back(mk(1, 1, 0, 34'h0,            1, 32'h18,  1, 32'h10,  0));
        vecs.push_back(mk(1, 0, 0, 34'h0,            0, 32'h1C,  1, 32'h14,  0));
        vecs.push_back(mk(1, 1, 1, 34'h0_0000_0100,  1, 32'h1C,  1, 32'h14,  0));
        vecs.push_back(mk(1, 1, 0, 34'h0,            1, 32'h100, 0, 32'h0,   0));
        vecs.push_back(mk(1, 1, 0, 34'h0,            1, 32'h104, 0, 32'h0,   0));
        vecs.push_back(mk(1, 1, 0, 34'h0,            1, 32'h108, 1, 32'h100, 0));
        vecs.push_back(mk(1, 1, 1, 34'h1_0000_0042,  1, 32'h10C, 1, 32'h104, 0));
        vecs.push_back(mk(1, 1, 0, 34'h0,            1, 32'h40,  0, 32'h0,   1));
        vecs.push_back(mk(1, 1, 0, 34'h0,            1, 32'h44,  0, 32'h0,   1));
        vecs.push_back(mk(1, 1, 0, 34'h0,            1, 32'h48,  1, 32'h40,  1));
        vecs.push_back(mk(1, 1, 0, 34'h0,            1, 32'h4C,  1, 32'h44,  1));
        vecs.push_back(mk(0, 1, 0, 34'h0,            1, 32'h50,  1, 32'h48,  1));
        vecs.push_back(mk(1, 1, 0, 34'h0,            0, 32'h0,   0, 32'h0,   0));
        vecs.push_back(mk(1, 1, 0, 34'h0,            1, 32'h0,   0, 32'h0,   0));
        vecs.push_back(mk(1, 1, 0, 34'h0,            1, 32'h4,   0, 32'h0,   0));
        vecs.push_back(mk(1, 1, 0, 34'h0,            1, 32'h8,   1, 32'h0,   0));

        @(negedge clk);
        tick();

        for (int i = 0; i < vecs.size(); i++) begin
            rst_n         = vecs[i].rst;
            fif.if_ready  = vecs[i].rdy;
            redirect      = vecs[i].redir;
            next_pc_in    = vecs[i].npc;
            @(negedge clk);
            chk($sformatf("v%0d_req", i),   fif.imem_req,  vecs[i].req);
            chk($sformatf("v%0d_addr", i),  fif.imem_addr, vecs[i].addr);
            chk($sformatf("v%0d_valid", i), fif.if_valid,  vecs[i].vld);
            chk($sformatf("v%0d_pc", i),    fif.if_pc,     vecs[i].pc);
            chk($sformatf("v%0d_instr", i), fif.if_instr,  vecs[i].vld ? mem_word(vecs[i].pc) : 32'h0);
            chk($sformatf("v%0d_err", i),   addr_err,      vecs[i].err);
            tick();
        end

        rst_n_w  = 1'b1;
        redirect = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk($sformatf("wrap%0d_req", k),   wif.imem_req,  w_req[k]);
            chk($sformatf("wrap%0d_addr", k),  wif.imem_addr, w_addr[k]);
            chk($sformatf("wrap%0d_valid", k), wif.if_valid,  w_vld[k]);
            chk($sformatf("wrap%0d_pc", k),    wif.if_pc,     w_pc[k]);
            chk($sformatf("wrap%0d_err", k),   addr_err_w,    1'b0);
            tick();
        end

        rst_n = 1'b0;
        @(negedge clk);
        tick();
        rst_n    = 1'b1;
        exp_next = 32'h0;
        exp_err  = 1'b0;
        since    = 0;
        for (int c = 0; c < 3000; c++) begin
            fif.if_ready = ($urandom_range(0, 3) != 0);
            redirect     = ($urandom_range(0, 15) == 0);
            t[31:0]      = $urandom();
            t[33:32]     = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            if ($urandom_range(0, 3) != 0) t[1:0] = 2'b00;
            next_pc_in   = t;
            @(negedge clk);
            chk("rnd_valid", fif.if_valid, (since >= 3));
            chk("rnd_err", addr_err, exp_err);
            if (since >= 3 && fif.if_ready && !redirect) begin
                chk("rnd_pc", fif.if_pc, exp_next);
                chk("rnd_instr", fif.if_instr, mem_word(exp_next));
                exp_next = exp_next + 32'd4;
            end
            if (redirect) begin
                exp_next = t[31:0] & 32'hFFFF_FFFC;
                exp_err  = exp_err | (t[33:32] != 2'b00) | (t[1:0] != 2'b00);
                since    = 1;
            end else if (since < 3) begin
                since++;
            end
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
